// File: rtl/march_element_sequencer_pkg.sv
// March element sequencer: shared constants and FSM state encoding.
// Address-mode constants match the BIST address counter.
package march_element_sequencer_pkg;

  localparam int ADDR_WIDTH = 8;

  localparam logic ADMD_LIUD = 1'b0;
  localparam logic ADMD_PRUD = 1'b1;

  localparam logic [ADDR_WIDTH-1:0] ADMD_LIUD_FIRST = '0;
  localparam logic [ADDR_WIDTH-1:0] ADMD_LIUD_LAST  = '1;
  localparam logic [ADDR_WIDTH-1:0] ADMD_PR_SEED    = 8'h01;

  localparam int ADMD_LIUD_COUNT = 256;
  localparam int ADMD_PR_PERIOD  = 255;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_OPS  = 3'd2,
    ST_STEP = 3'd3,
    ST_DONE = 3'd4
  } mes_state_e;

endpackage

// File: rtl/march_element_sequencer.sv
// Runs one march element: positions the address counter, issues
// nops+1 ops per address, steps through every address, then pulses done.
module march_element_sequencer
  import march_element_sequencer_pkg::*;
#(
  parameter int tasw = ADDR_WIDTH,
  parameter int opw  = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_in,
  input  logic            abort_in,
  input  logic            admd_in,
  input  logic            updwn_in,
  input  logic [opw-1:0]  nops_in,
  input  logic [tasw-1:0] tas_in,
  output logic            admd_out,
  output logic            updwn_out,
  output logic            s_out,
  output logic            r_out,
  output logic            hold_out,
  output logic            op_valid_out,
  output logic [opw-1:0]  op_idx_out,
  output logic            elem_done_out,
  output logic            busy_out
);

  localparam int VW = tasw + 1;
  localparam logic [VW-1:0] TC_LIUD = VW'(ADMD_LIUD_COUNT - 1);
  localparam logic [VW-1:0] TC_PRUD = VW'(ADMD_PR_PERIOD - 1);

  mes_state_e     state_q, state_d;
  logic           admd_q, admd_d;
  logic           updwn_q, updwn_d;
  logic [opw-1:0] nops_q, nops_d;
  logic [opw-1:0] op_idx_q, op_idx_d;
  logic [VW-1:0]  visit_q, visit_d;
  logic [VW-1:0]  term_cnt;
  logic           last_op;

  // The op address comes straight from the counter to the memory port.
  logic unused_tas;
  assign unused_tas = ^tas_in;

  assign term_cnt = (admd_q == ADMD_PRUD) ? TC_PRUD : TC_LIUD;
  assign last_op  = (op_idx_q == nops_q);

  always_comb begin
    state_d  = state_q;
    admd_d   = admd_q;
    updwn_d  = updwn_q;
    nops_d   = nops_q;
    op_idx_d = op_idx_q;
    visit_d  = visit_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_in) begin
          admd_d   = admd_in;
          updwn_d  = updwn_in;
          nops_d   = nops_in;
          visit_d  = '0;
          op_idx_d = '0;
          state_d  = ST_LOAD;
        end
      end
      ST_LOAD: state_d = ST_OPS;
      ST_OPS: begin
        if (last_op) begin
          op_idx_d = '0;
          if (visit_q == term_cnt) begin
            state_d = ST_DONE;
          end else begin
            visit_d = visit_q + VW'(1);
            state_d = ST_STEP;
          end
        end else begin
          op_idx_d = op_idx_q + opw'(1);
        end
      end
      ST_STEP: state_d = ST_OPS;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (abort_in && state_q != ST_IDLE) begin
      state_d  = ST_IDLE;
      op_idx_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      admd_q   <= ADMD_LIUD;
      updwn_q  <= 1'b0;
      nops_q   <= '0;
      op_idx_q <= '0;
      visit_q  <= '0;
    end else begin
      state_q  <= state_d;
      admd_q   <= admd_d;
      updwn_q  <= updwn_d;
      nops_q   <= nops_d;
      op_idx_q <= op_idx_d;
      visit_q  <= visit_d;
    end
  end

  always_comb begin
    hold_out      = 1'b1;
    s_out         = 1'b0;
    r_out         = 1'b0;
    op_valid_out  = 1'b0;
    elem_done_out = 1'b0;
    unique case (state_q)
      ST_LOAD: begin
        s_out = ~updwn_q;
        r_out = updwn_q;
      end
      ST_OPS:  op_valid_out  = 1'b1;
      ST_STEP: hold_out      = 1'b0;
      ST_DONE: elem_done_out = 1'b1;
      default: ;
    endcase
  end

  assign busy_out   = (state_q != ST_IDLE);
  assign admd_out   = admd_q;
  assign updwn_out  = updwn_q;
  assign op_idx_out = op_idx_q;

endmodule
